// File: rtl/car_sensor_filter_pkg.sv
// Shared definitions for the Stoplight sensor path:
// light encodings and the sensor qualifier FSM states.
`timescale 1ns/1ps
package car_sensor_filter_pkg;

  localparam logic [2:0] GRN = 3'b100;
  localparam logic [2:0] YLW = 3'b010;
  localparam logic [2:0] RED = 3'b001;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESENT   = 2'd2,
    RELEASING = 2'd3
  } sense_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit,
// with synchronous active-high reset.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/car_sensor_filter.sv
// Loop-detector qualifier: sync, debounce, hold-off, stuck fault.
// Optional arrival counter enabled by defining CAR_COUNT_EN.
`timescale 1ns/1ps
module car_sensor_filter
  import car_sensor_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 3,
  parameter int HOLD_CYC     = 2,
  parameter int STUCK_CYC    = 20
`ifdef CAR_COUNT_EN
  , parameter int CNT_W      = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  output logic car_present,
  output logic car_arrive,
  output logic sensor_fault
`ifdef CAR_COUNT_EN
  , output logic [CNT_W-1:0] car_count
`endif
);

  localparam int MAXC = (DEBOUNCE_CYC > HOLD_CYC) ?
                        DEBOUNCE_CYC : HOLD_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int SW = $clog2(STUCK_CYC + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYC);

  logic         s;
  sense_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] stuck_cnt, stuck_nx;
  logic         arrive_nx;
  logic         fault_nx;
  logic         present_nx;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sensor_raw),
    .q   (s)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    arrive_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nx = ARMING;
          cnt_nx   = CW'(1);
        end
      end
      ARMING: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx  = PRESENT;
          cnt_nx    = '0;
          arrive_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      PRESENT: begin
        // The first low sample already counts toward the hold-off.
        if (!s) begin
          if (HOLD_CYC > 1) begin
            state_nx = RELEASING;
            cnt_nx   = CW'(1);
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
      end
      RELEASING: begin
        if (s) begin
          state_nx = PRESENT;
          cnt_nx   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    if (!s)
      stuck_nx = '0;
    else if (stuck_cnt == STUCK_MAX)
      stuck_nx = stuck_cnt;
    else
      stuck_nx = stuck_cnt + SW'(1);
    fault_nx   = sensor_fault | (stuck_nx == STUCK_MAX);
    present_nx = (state_nx == PRESENT) |
                 (state_nx == RELEASING) | fault_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stuck_cnt    <= '0;
      car_present  <= 1'b0;
      car_arrive   <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      stuck_cnt    <= stuck_nx;
      car_present  <= present_nx;
      car_arrive   <= arrive_nx;
      sensor_fault <= fault_nx;
    end
  end

`ifdef CAR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      car_count <= '0;
    else if (arrive_nx)
      car_count <= car_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_car_sensor_filter.sv
// Bench for car_sensor_filter: vector table, corner sequences,
// and randomized run-length stimulus against a reference model.
`timescale 1ns/1ps
module tb_car_sensor_filter;

  localparam int DEB   = 3;
  localparam int HOLD  = 2;
  localparam int STUCK = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_raw = 1'b0;
  logic car_present, car_arrive, sensor_fault;
`ifdef CAR_COUNT_EN
  logic [3:0] car_count;
`endif

  int errors = 0;
  int checks = 0;

  always #2.5 clk = ~clk;

  car_sensor_filter #(
    .DEBOUNCE_CYC (DEB),
    .HOLD_CYC     (HOLD),
    .STUCK_CYC    (STUCK)
`ifdef CAR_COUNT_EN
    , .CNT_W      (4)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_raw   (sensor_raw),
    .car_present  (car_present),
    .car_arrive   (car_arrive),
    .sensor_fault (sensor_fault)
`ifdef CAR_COUNT_EN
    , .car_count  (car_count)
`endif
  );

  // Reference: runs of high/low synchronized samples decide the level.
  logic       m_f1 = 0, m_f2 = 0;
  int         hi_run = 0, lo_run = 0;
  logic       m_lvl = 0, m_fault = 0, m_arrive = 0, m_present = 0;
  logic [3:0] m_count = 0;
  int         arrivals = 0;

  task automatic model(input logic r, input logic x);
    logic sv;
    if (r) begin
      m_f1 = 0; m_f2 = 0; hi_run = 0; lo_run = 0;
      m_lvl = 0; m_fault = 0; m_arrive = 0; m_count = 0;
    end else begin
      sv = m_f2;
      m_f2 = m_f1;
      m_f1 = x;
      if (sv) begin
        if (hi_run < 1000) hi_run++;
        lo_run = 0;
      end else begin
        if (lo_run < 1000) lo_run++;
        hi_run = 0;
      end
      m_arrive = 0;
      if (!m_lvl && hi_run == DEB) begin
        m_lvl = 1; m_arrive = 1; m_count++;
      end else if (m_lvl && lo_run == HOLD) begin
        m_lvl = 0;
      end
      if (hi_run >= STUCK) m_fault = 1;
    end
    m_present = m_lvl | m_fault;
  endtask

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step(input logic r, input logic x);
    rst = r;
    sensor_raw = x;
    @(posedge clk);
    model(r, x);
    #1;
    if (car_arrive === 1'b1) arrivals++;
    chk("present", 8'(car_present), 8'(m_present));
    chk("arrive", 8'(car_arrive), 8'(m_arrive));
    chk("fault", 8'(sensor_fault), 8'(m_fault));
`ifdef CAR_COUNT_EN
    chk("count", 8'(car_count), 8'(m_count));
`endif
  endtask

  typedef struct {
    logic r;
    logic x;
    logic p;
    logic a;
    logic f;
  } vec_t;

  vec_t tab[20];

  initial begin
    int runlen;
    logic lvl;

    // Reset with raw high, clean car, release, then a glitch.
    tab[0]  = '{1, 1, 0, 0, 0};
    tab[1]  = '{1, 1, 0, 0, 0};
    tab[2]  = '{0, 1, 0, 0, 0};
    tab[3]  = '{0, 1, 0, 0, 0};
    tab[4]  = '{0, 1, 0, 0, 0};
    tab[5]  = '{0, 1, 0, 0, 0};
    tab[6]  = '{0, 1, 1, 1, 0};
    tab[7]  = '{0, 1, 1, 0, 0};
    tab[8]  = '{0, 0, 1, 0, 0};
    tab[9]  = '{0, 0, 1, 0, 0};
    tab[10] = '{0, 0, 1, 0, 0};
    tab[11] = '{0, 0, 0, 0, 0};
    tab[12] = '{0, 0, 0, 0, 0};
    tab[13] = '{0, 1, 0, 0, 0};
    tab[14] = '{0, 1, 0, 0, 0};
    tab[15] = '{0, 0, 0, 0, 0};
    tab[16] = '{0, 0, 0, 0, 0};
    tab[17] = '{0, 0, 0, 0, 0};
    tab[18] = '{0, 0, 0, 0, 0};
    tab[19] = '{0, 0, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      step(tab[i].r, tab[i].x);
      chk($sformatf("tab%0d_present", i), 8'(car_present), 8'(tab[i].p));
      chk($sformatf("tab%0d_arrive", i), 8'(car_arrive), 8'(tab[i].a));
      chk($sformatf("tab%0d_fault", i), 8'(sensor_fault), 8'(tab[i].f));
    end

    // Reset in the middle of PRESENT.
    for (int i = 0; i < 6; i++) step(0, 1);
    chk("pre_rst_present", 8'(car_present), 8'd1);
    step(1, 1);
    chk("mid_rst_present", 8'(car_present), 8'd0);
    step(1, 0);

    // Dropout of one edge while present.
    arrivals = 0;
    for (int i = 0; i < 8; i++) step(0, 1);
    step(0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1);
      chk("dropout_present", 8'(car_present), 8'd1);
    end
    chk("dropout_arrivals", 8'(arrivals), 8'd1);
    step(1, 0);

    // Stuck sensor.
    for (int e = 1; e <= 30; e++) begin
      step(0, 1);
      if (e == 21) chk("stuck_e21", 8'(sensor_fault), 8'd0);
      if (e == 22) chk("stuck_e22", 8'(sensor_fault), 8'd1);
    end
    for (int i = 0; i < 10; i++) step(0, 0);
    chk("stuck_hold_present", 8'(car_present), 8'd1);
    chk("stuck_hold_fault", 8'(sensor_fault), 8'd1);
    step(1, 0);
    chk("stuck_rst_present", 8'(car_present), 8'd0);
    chk("stuck_rst_fault", 8'(sensor_fault), 8'd0);

    // Seventeen clean cars.
    arrivals = 0;
    for (int c = 0; c < 17; c++) begin
      for (int i = 0; i < 6; i++) step(0, 1);
      for (int i = 0; i < 6; i++) step(0, 0);
    end
    chk("cars17_arrivals", 8'(arrivals), 8'd17);
`ifdef CAR_COUNT_EN
    chk("cars17_count", 8'(car_count), 8'd1);
`endif

    // Randomized run lengths with occasional resets.
    runlen = 0;
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (runlen == 0) begin
        lvl = ~lvl;
        runlen = ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(1, 26)) : int'($urandom_range(1, 6));
      end
      step($urandom_range(0, 199) == 0, lvl);
      runlen--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
